// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between fetch (IF) and data-memory (DM) requesters.
// Optional IF anti-starvation guard is enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_stall,
  input  logic              dm_rd,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GNT_IF  = 3'd1,
    GNT_DM  = 3'd2,
    RESP_IF = 3'd3,
    RESP_DM = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_done_q, if_done_d;
  logic              dm_done_q, dm_done_d;
  logic              err_q, err_d;

  logic dm_req;
  logic dm_illegal;
  logic starve_hit;
  logic grant_if;

  assign dm_req     = dm_rd | dm_wr;
  // Conflicting direction or an odd (unaligned) word address never reaches memory.
  assign dm_illegal = (dm_rd & dm_wr) | dm_addr[0];

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  assign starve_hit = if_req & (starve_cnt_q == CNT_MAX);
`else
  assign starve_hit = 1'b0;
`endif

  // DM normally wins: it carries the older instruction in the pipeline.
  assign grant_if = if_req & (~dm_req | starve_hit);

  always_comb begin
    state_d     = state_q;
    mem_en_d    = 1'b0;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
    err_d       = 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
    starve_cnt_d = starve_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (grant_if) begin
          state_d     = GNT_IF;
          mem_en_d    = 1'b1;
          mem_wr_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
`ifdef MEM_ARB_STARVE_GUARD_EN
          starve_cnt_d = '0;
`endif
        end else if (dm_req) begin
          if (dm_illegal) begin
            state_d    = RESP_DM;
            dm_done_d  = 1'b1;
            err_d      = 1'b1;
            dm_rdata_d = '0;
          end else begin
            state_d     = GNT_DM;
            mem_en_d    = 1'b1;
            mem_wr_d    = dm_wr;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
`ifdef MEM_ARB_STARVE_GUARD_EN
            if (if_req && (starve_cnt_q < CNT_MAX)) begin
              starve_cnt_d = starve_cnt_q + 1'b1;
            end
`endif
          end
        end
      end

      GNT_IF: begin
        if (mem_ack) begin
          state_d    = RESP_IF;
          if_done_d  = 1'b1;
          if_rdata_d = mem_rdata;
        end
      end

      GNT_DM: begin
        if (mem_ack) begin
          state_d   = RESP_DM;
          dm_done_d = 1'b1;
          if (!mem_wr_q) begin
            dm_rdata_d = mem_rdata;
          end
        end
      end

      // One-cycle bubble so the requester can drop or change its request.
      RESP_IF: state_d = IDLE;
      RESP_DM: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      err_q       <= 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
      starve_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
      err_q       <= err_d;
`ifdef MEM_ARB_STARVE_GUARD_EN
      starve_cnt_q <= starve_cnt_d;
`endif
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_done   = if_done_q;
  assign dm_done   = dm_done_q;
  assign err       = err_q;

  assign if_stall  = if_req & ~if_done_q;
  assign dm_stall  = dm_req & ~dm_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table for single transactions,
// hand sequences for reset, collision and starvation behaviour.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_done;
  logic        if_stall;
  logic        dm_rd;
  logic        dm_wr;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic [15:0] dm_rdata;
  logic        dm_done;
  logic        dm_stall;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        err;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory responder: acks rsp_delay cycles after seeing mem_en.
  bit          auto_mem = 1'b0;
  int          rsp_delay = 0;
  logic [15:0] rsp_data = 16'h0;

  initial begin
    int wait_cnt;
    bit pend;
    pend = 1'b0;
    wait_cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = 16'hDEAD;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      mem_rdata = 16'hDEAD;
      if (!rst_n || !auto_mem) begin
        pend = 1'b0;
      end else begin
        if (mem_en) begin
          pend = 1'b1;
          wait_cnt = rsp_delay;
        end
        if (pend) begin
          if (wait_cnt == 0) begin
            mem_ack = 1'b1;
            mem_rdata = rsp_data;
            pend = 1'b0;
          end else begin
            wait_cnt--;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          is_if;
    bit          rd;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          delay;
    logic [15:0] rdata;
    bit          exp_en;
    int          exp_done;
    logic [15:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input vec_t v, input int idx);
    int          en_cnt;
    int          en_cyc;
    int          done_cyc;
    int          stall_cnt;
    logic        s_wr;
    logic [15:0] s_addr;
    logic [15:0] s_wdata;
    logic [15:0] s_rdata;
    logic        s_err;
    logic        s_stall;
    string       tag;
    tag = $sformatf("v%0d", idx);
    rsp_delay = v.delay;
    rsp_data  = v.rdata;
    if_req   = v.is_if;
    if_addr  = v.is_if ? v.addr : 16'h0;
    dm_rd    = !v.is_if && v.rd;
    dm_wr    = !v.is_if && v.wr;
    dm_addr  = v.is_if ? 16'h0 : v.addr;
    dm_wdata = v.wdata;
    en_cnt = 0; en_cyc = -1; done_cyc = -1; stall_cnt = 0;
    s_wr = 1'bx; s_addr = 'x; s_wdata = 'x; s_rdata = 'x; s_err = 1'bx; s_stall = 1'bx;
    for (int c = 0; c < 20 && done_cyc < 0; c++) begin
      @(negedge clk);
      if (mem_en) begin
        en_cnt++;
        en_cyc = c; s_wr = mem_wr; s_addr = mem_addr; s_wdata = mem_wdata;
      end
      if (v.is_if ? if_done : dm_done) begin
        done_cyc = c;
        s_rdata  = v.is_if ? if_rdata : dm_rdata;
        s_err    = err;
        s_stall  = v.is_if ? if_stall : dm_stall;
      end else if (v.is_if ? if_stall : dm_stall) begin
        stall_cnt++;
      end
      @(posedge clk);
      #1;
    end
    if_req = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0;
    check({tag, "_en_count"}, en_cnt, v.exp_en ? 1 : 0);
    if (v.exp_en) begin
      check({tag, "_en_cycle"}, en_cyc, 1);
      check({tag, "_mem_wr"}, s_wr, v.wr && !v.is_if);
      check({tag, "_mem_addr"}, s_addr, v.addr);
      if (v.wr && !v.is_if) check({tag, "_mem_wdata"}, s_wdata, v.wdata);
    end
    check({tag, "_done_cycle"}, done_cyc, v.exp_done);
    check({tag, "_rdata"}, s_rdata, v.exp_rdata);
    check({tag, "_err"}, s_err, v.exp_err);
    check({tag, "_stall_cycles"}, stall_cnt, v.exp_done);
    check({tag, "_stall_released"}, s_stall, 0);
    @(posedge clk);
    #1;
  endtask

  int          n_en;
  int          en_cyc_a[8];
  logic [15:0] en_addr_a[8];
  logic        en_wr_a[8];
  logic [15:0] en_wdata_a[8];
  int          dm_done_cyc;
  int          if_done_cyc;
  logic        if_stall_c2;
  logic [15:0] if_rd_done;

  // Runs free for ncyc cycles; requesters drop on their done unless DM is held.
  task automatic run_scn(input int ncyc, input bit hold_dm);
    bit drop_dm;
    bit drop_if;
    n_en = 0; dm_done_cyc = -1; if_done_cyc = -1; if_stall_c2 = 1'b0; if_rd_done = 16'h0;
    for (int i = 0; i < 8; i++) begin
      en_cyc_a[i] = -1; en_addr_a[i] = 16'h0; en_wr_a[i] = 1'b0; en_wdata_a[i] = 16'h0;
    end
    for (int c = 0; c < ncyc; c++) begin
      drop_dm = 1'b0;
      drop_if = 1'b0;
      @(negedge clk);
      if (mem_en && n_en < 8) begin
        en_cyc_a[n_en] = c; en_addr_a[n_en] = mem_addr;
        en_wr_a[n_en] = mem_wr; en_wdata_a[n_en] = mem_wdata;
        n_en++;
      end
      if (dm_done) begin
        if (dm_done_cyc < 0) dm_done_cyc = c;
        drop_dm = !hold_dm;
      end
      if (if_done) begin
        if (if_done_cyc < 0) begin
          if_done_cyc = c;
          if_rd_done = if_rdata;
        end
        drop_if = 1'b1;
      end
      if (c == 2) if_stall_c2 = if_stall;
      @(posedge clk);
      #1;
      if (drop_dm) begin dm_rd = 1'b0; dm_wr = 1'b0; end
      if (drop_if) if_req = 1'b0;
    end
    if_req = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_bus"}, {mem_addr, mem_wdata}, 32'h0);
    check({tag, "_rdata"}, {if_rdata, dm_rdata}, 32'h0);
    check({tag, "_ctl"}, {25'h0, if_done, if_stall, dm_done, dm_stall, mem_en, mem_wr, err}, 32'h0);
  endtask

  initial begin
    int first_if;
    int quiet_cnt;

    //                is_if rd wr addr      wdata     dly rdata     en done exp_rdata  err
    vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000, 2, 16'h1234, 1'b1, 4, 16'h1234, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 16'h0102, 16'h0000, 0, 16'h00FF, 1'b1, 2, 16'h00FF, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 1, 16'h3333, 1'b1, 3, 16'h00FF, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 16'h0020, 16'h2222, 0, 16'h4444, 1'b0, 1, 16'h0000, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 16'h0101, 16'h0000, 0, 16'h4444, 1'b0, 1, 16'h0000, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 16'h0003, 16'h1111, 0, 16'h4444, 1'b0, 1, 16'h0000, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 16'h0200, 16'h0000, 1, 16'hA5A5, 1'b1, 3, 16'hA5A5, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 16'h0042, 16'h0000, 0, 16'h5678, 1'b1, 2, 16'h5678, 1'b0};

    rst_n = 1'b0;
    if_req = 1'b0; if_addr = 16'h0;
    dm_rd = 1'b0; dm_wr = 1'b0; dm_addr = 16'h0; dm_wdata = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    auto_mem = 1'b1;
    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);
    check("if_rdata_held", if_rdata, 16'h5678);

    // Reset while a DM write sits in GNT_DM, then a stray ack afterwards.
    auto_mem = 1'b0;
    dm_wr = 1'b1; dm_addr = 16'h0300; dm_wdata = 16'h7777;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("midrst_en", mem_en, 1'b1);
    check("midrst_addr", mem_addr, 16'h0300);
    @(posedge clk);
    #1;
    dm_wr = 1'b0; dm_addr = 16'h0; dm_wdata = 16'h0;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    mem_ack = 1'b1;
    mem_rdata = 16'h9999;
    quiet_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (dm_done || if_done || mem_en || err) quiet_cnt++;
    end
    check("stray_ack_ignored", quiet_cnt, 0);
    check("stray_ack_rdata", dm_rdata, 16'h0000);
    @(posedge clk);
    #1;

    // Same-cycle collision: DM write goes first, IF follows after the bubble.
    auto_mem = 1'b1;
    rsp_delay = 0;
    rsp_data = 16'h4321;
    if_req = 1'b1; if_addr = 16'h0080;
    dm_wr = 1'b1; dm_addr = 16'h0010; dm_wdata = 16'hBEEF;
    run_scn(10, 1'b0);
    check("col_n_en", n_en, 2);
    check("col_dm_en_cyc", en_cyc_a[0], 1);
    check("col_dm_wr", en_wr_a[0], 1'b1);
    check("col_dm_addr", en_addr_a[0], 16'h0010);
    check("col_dm_wdata", en_wdata_a[0], 16'hBEEF);
    check("col_dm_done_cyc", dm_done_cyc, 2);
    check("col_if_stall_c2", if_stall_c2, 1'b1);
    check("col_if_en_cyc", en_cyc_a[1], 4);
    check("col_if_wr", en_wr_a[1], 1'b0);
    check("col_if_addr", en_addr_a[1], 16'h0080);
    check("col_if_done_cyc", if_done_cyc, 5);
    check("col_if_rdata", if_rd_done, 16'h4321);
    @(posedge clk);
    #1;

    // Back-to-back DM reads with IF waiting.
    rsp_data = 16'h1111;
    if_req = 1'b1; if_addr = 16'h0500;
    dm_rd = 1'b1; dm_addr = 16'h0400;
    run_scn(24, 1'b1);
    first_if = -1;
    for (int i = 0; i < n_en; i++) begin
      if (first_if < 0 && en_addr_a[i] == 16'h0500) first_if = i;
    end
    check("starve_n_grants", n_en, 8);
    check("starve_first_is_dm", en_addr_a[0], 16'h0400);
`ifdef MEM_ARB_STARVE_GUARD_EN
    check("guard_if_after_3_dm", first_if, 3);
    check("guard_if_done_cyc", if_done_cyc, 11);
`else
    check("noguard_if_starved", first_if, -1);
    check("noguard_if_done_cyc", if_done_cyc, -1);
`endif
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
